// File: rtl/gu_scheduler.sv
// rtl/gu_scheduler.sv - sequences up to three graphics units per frame and muxes their pixel writes to the VGA port
// A per-unit watchdog forces progress if a unit never reports done; overrun/timeout are sticky status flags.
module gu_scheduler #(
   parameter logic [17:0] WDOG_MAX = 18'd131071
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        frame_tick,
   input  logic [2:0]  enable_mask,
   input  logic        clr_status,
   output logic [2:0]  gu_plot,
   input  logic [2:0]  gu_done,
   input  logic [2:0]  gu_wren,
   input  logic [26:0] gu_x,
   input  logic [23:0] gu_y,
   input  logic [8:0]  gu_colour,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_wren,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun,
   output logic        timeout
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

   state_t      state, state_next;
   logic [2:0]  active_mask, active_mask_next;
   logic [1:0]  idx, idx_next;
   logic [17:0] wdog, wdog_next, wdog_inc;
   logic [1:0]  low_idx, above_idx;
   logic        low_found, above_found;
   logic        sel_done, sel_wren, wdog_exp, advance;
   logic [8:0]  sel_x;
   logic [7:0]  sel_y;
   logic [2:0]  sel_colour;

   always_comb begin
      sel_done   = 1'b0;
      sel_wren   = 1'b0;
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      case (idx)
         2'd0: begin sel_done = gu_done[0]; sel_wren = gu_wren[0]; sel_x = gu_x[8:0];   sel_y = gu_y[7:0];   sel_colour = gu_colour[2:0]; end
         2'd1: begin sel_done = gu_done[1]; sel_wren = gu_wren[1]; sel_x = gu_x[17:9];  sel_y = gu_y[15:8];  sel_colour = gu_colour[5:3]; end
         2'd2: begin sel_done = gu_done[2]; sel_wren = gu_wren[2]; sel_x = gu_x[26:18]; sel_y = gu_y[23:16]; sel_colour = gu_colour[8:6]; end
         default: ;
      endcase
   end

   // Descending scans so the lowest qualifying index is the one left standing.
   always_comb begin
      low_found   = 1'b0;
      low_idx     = 2'd0;
      above_found = 1'b0;
      above_idx   = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (enable_mask[i]) begin
            low_found = 1'b1;
            low_idx   = 2'(i);
         end
         if (active_mask[i] && (2'(i) > idx)) begin
            above_found = 1'b1;
            above_idx   = 2'(i);
         end
      end
   end

   assign wdog_inc = wdog + 18'd1;
   // Done takes priority over expiry, so a simultaneous done never flags a timeout.
   assign wdog_exp = (state == S_WAIT) && !sel_done && (wdog_inc >= WDOG_MAX);
   assign advance  = (state == S_WAIT) && (sel_done || wdog_exp);
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_next       = state;
      idx_next         = idx;
      active_mask_next = active_mask;
      wdog_next        = wdog;
      gu_plot          = 3'b000;
      case (state)
         S_IDLE: begin
            if (frame_tick) begin
               active_mask_next = enable_mask;
               idx_next         = low_idx;
               state_next       = low_found ? S_LAUNCH : S_FINISH;
            end
         end
         S_LAUNCH: begin
            gu_plot    = 3'b001 << idx;
            wdog_next  = '0;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (advance) begin
               if (above_found) begin
                  idx_next   = above_idx;
                  state_next = S_LAUNCH;
               end else begin
                  state_next = S_FINISH;
               end
            end else begin
               wdog_next = wdog_inc;
            end
         end
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         idx         <= '0;
         active_mask <= '0;
         wdog        <= '0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
         vga_wren    <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         active_mask <= active_mask_next;
         wdog        <= wdog_next;
         frame_done  <= (state == S_FINISH);
         overrun     <= (frame_tick && (state != S_IDLE)) || (overrun && !clr_status);
         timeout     <= wdog_exp || (timeout && !clr_status);
         if (state == S_WAIT) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
         end
         // The exiting WAIT cycle's write is dropped so wren is low once the unit is released.
         vga_wren <= (state == S_WAIT) && sel_wren && !advance;
      end
   end

endmodule

// File: tb/tb_gu_scheduler.sv
// tb/tb_gu_scheduler.sv - directed self-checking bench for gu_scheduler
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gu_scheduler;

   logic        clk;
   logic        resetn;
   logic        frame_tick;
   logic [2:0]  enable_mask;
   logic        clr_status;
   logic [2:0]  gu_plot;
   logic [2:0]  gu_done;
   logic [2:0]  gu_wren;
   logic [26:0] gu_x;
   logic [23:0] gu_y;
   logic [8:0]  gu_colour;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_wren;
   logic        busy;
   logic        frame_done;
   logic        overrun;
   logic        timeout;

   int n_assert = 0;
   int n_fail   = 0;

   int seq, n_plots, n_fd, last_plot_c, fd_c, to_c, busy_bad, onehot_bad;

   gu_scheduler #(.WDOG_MAX(18'd16)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .frame_tick  (frame_tick),
      .enable_mask (enable_mask),
      .clr_status  (clr_status),
      .gu_plot     (gu_plot),
      .gu_done     (gu_done),
      .gu_wren     (gu_wren),
      .gu_x        (gu_x),
      .gu_y        (gu_y),
      .gu_colour   (gu_colour),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_wren    (vga_wren),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one frame; units in 'responds' raise done 'delay' cycles after their plot.
   // Cycle 0 is the first cycle after the frame_tick edge.
   task automatic run_frame(input logic [2:0] mask, input logic [2:0] responds,
                            input int delay, input int retick);
      int cd [3];
      bit seen_fd;
      cd = '{-1, -1, -1};
      seq = 0; n_plots = 0; n_fd = 0; last_plot_c = -1; fd_c = -1; to_c = -1;
      busy_bad = 0; onehot_bad = 0; seen_fd = 0;
      enable_mask = mask;
      frame_tick  = 1'b1;
      step();
      frame_tick  = 1'b0;
      for (int c = 0; c < 100 && !seen_fd; c++) begin
         if (gu_plot != 3'b000) begin
            if ($countones(gu_plot) != 1) onehot_bad++;
            for (int i = 0; i < 3; i++) begin
               if (gu_plot[i]) begin
                  seq = (seq << 2) | i;
                  n_plots++;
                  last_plot_c = c;
                  if (responds[i]) cd[i] = delay;
               end
            end
         end
         if (timeout && to_c < 0) to_c = c;
         if (frame_done) begin
            n_fd++;
            fd_c = c;
            seen_fd = 1;
         end else if (!busy) begin
            busy_bad++;
         end
         for (int i = 0; i < 3; i++) begin
            gu_done[i] = (cd[i] == 0);
            if (cd[i] >= 0) cd[i]--;
         end
         frame_tick = (c == retick);
         step();
      end
      gu_done    = 3'b000;
      frame_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (frame_done) n_fd++;
         step();
      end
   endtask

   initial begin
      int bad;
      resetn      = 1'b0;
      frame_tick  = 1'b0;
      enable_mask = 3'b000;
      clr_status  = 1'b0;
      gu_done     = 3'b000;
      gu_wren     = 3'b000;
      gu_x        = '0;
      gu_y        = '0;
      gu_colour   = '0;
      step();
      step();
      chk("reset_outputs", {gu_plot, vga_x, vga_y, vga_colour, vga_wren, busy, frame_done, overrun, timeout}, 0);
      resetn = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // All three units, done 10 cycles after each plot
      run_frame(3'b111, 3'b111, 10, -1);
      chk("all_plot_count", n_plots, 3);
      chk("all_plot_order", seq, 6);
      chk("all_frame_done_once", n_fd, 1);
      chk("all_busy_throughout", busy_bad, 0);
      chk("all_onehot", onehot_bad, 0);
      chk("all_fd_latency", fd_c - last_plot_c, 12);
      chk("all_no_timeout", to_c, -1);

      // Write mux follows GU1 only
      enable_mask = 3'b010;
      frame_tick  = 1'b1;
      step();
      frame_tick  = 1'b0;
      chk("mux_plot_gu1", gu_plot, 3'b010);
      gu_wren   = 3'b111;
      gu_x      = {9'd5, 9'd319, 9'd7};
      gu_y      = {8'd3, 8'd239, 8'd4};
      gu_colour = {3'b010, 3'b101, 3'b011};
      step();
      chk("mux_wren_not_yet", vga_wren, 0);
      step();
      chk("mux_vga_x", vga_x, 319);
      chk("mux_vga_y", vga_y, 239);
      chk("mux_vga_colour", vga_colour, 3'b101);
      chk("mux_vga_wren", vga_wren, 1);
      gu_wren = 3'b101;
      gu_done = 3'b101;
      step();
      chk("mux_other_wren_ignored", vga_wren, 0);
      chk("mux_busy", busy, 1);
      step();
      chk("mux_other_done_ignored", frame_done, 0);
      gu_done = 3'b010;
      gu_wren = 3'b010;
      step();
      chk("mux_wren_after_exit", vga_wren, 0);
      gu_done = 3'b000;
      gu_wren = 3'b000;
      step();
      chk("mux_frame_done", frame_done, 1);
      step();

      // Empty mask, plus a tick during FINISH with clr_status in the same cycle
      enable_mask = 3'b000;
      frame_tick  = 1'b1;
      step();
      frame_tick  = 1'b0;
      chk("empty_fd_not_yet", frame_done, 0);
      chk("empty_no_plot_1", gu_plot, 0);
      frame_tick  = 1'b1;
      clr_status  = 1'b1;
      step();
      frame_tick  = 1'b0;
      chk("empty_fd_2_cycles", frame_done, 1);
      chk("empty_no_plot_2", gu_plot, 0);
      chk("finish_tick_overrun", overrun, 1);
      chk("finish_tick_dropped", busy, 0);
      step();
      clr_status = 1'b0;
      chk("clr_overrun_a", overrun, 0);
      chk("empty_fd_pulse", frame_done, 0);

      // Watchdog: GU2 never answers
      run_frame(3'b101, 3'b001, 3, -1);
      chk("wd_plot_count", n_plots, 2);
      chk("wd_plot_order", seq, 2);
      chk("wd_timeout_latency", to_c - last_plot_c, 17);
      chk("wd_fd_latency", fd_c - last_plot_c, 18);
      chk("wd_frame_done_once", n_fd, 1);
      chk("wd_timeout_sticky", timeout, 1);
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      chk("wd_timeout_cleared", timeout, 0);

      // Second tick during GU0 WAIT
      run_frame(3'b001, 3'b001, 10, 4);
      chk("ovr_flag", overrun, 1);
      chk("ovr_plot_count", n_plots, 1);
      chk("ovr_frame_done_once", n_fd, 1);
      chk("ovr_fd_latency", fd_c - last_plot_c, 12);
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // Asynchronous reset during GU1 WAIT
      enable_mask = 3'b010;
      frame_tick  = 1'b1;
      step();
      frame_tick  = 1'b0;
      gu_wren     = 3'b010;
      gu_x        = {9'd0, 9'd100, 9'd0};
      step();
      frame_tick  = 1'b1;
      step();
      frame_tick  = 1'b0;
      chk("rst_pre_wren", vga_wren, 1);
      chk("rst_pre_overrun", overrun, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("rst_async_outputs", {gu_plot, vga_x, vga_y, vga_colour, vga_wren, busy, frame_done, overrun, timeout}, 0);
      step();
      step();
      resetn  = 1'b1;
      gu_done = 3'b111;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (gu_plot != 3'b000 || busy) bad++;
      end
      gu_done = 3'b000;
      gu_wren = 3'b000;
      chk("rst_no_plot_after_release", bad, 0);
      run_frame(3'b001, 3'b001, 2, -1);
      chk("rst_recover_plots", n_plots, 1);
      chk("rst_recover_fd", n_fd, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gu_scheduler.md
GU_SCHEDULER -- requirements
Module: gu_scheduler

Interface
REQ-001 Parameter WDOG_MAX, default 18'd131071: WAIT-state cycle limit per graphics unit (GU) before a forced advance.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 frame_tick  input  1  one-cycle frame-start pulse.
REQ-005 enable_mask  input  3  per-GU enable; bit0 = background, bit1 = trailer, bit2 = sprite.
REQ-006 clr_status  input  1  clears the sticky overrun and timeout flags.
REQ-007 gu_plot  output  3  one-cycle start pulse to GU i.
REQ-008 gu_done  input  3  done level or pulse from GU i.
REQ-009 gu_wren  input  3  write enable from GU i.
REQ-010 gu_x  input  27  packed x, GU i at bits [9i+8:9i].
REQ-011 gu_y  input  24  packed y, GU i at bits [8i+7:8i].
REQ-012 gu_colour  input  9  packed colour, GU i at bits [3i+2:3i].
REQ-013 vga_x / vga_y / vga_colour / vga_wren  output  9/8/3/1  registered write port to the VGA adapter.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 frame_done  output  1  one-cycle pulse when the frame sequence ends.
REQ-016 overrun  output  1  sticky: frame_tick arrived while busy.
REQ-017 timeout  output  1  sticky: the watchdog forced an advance.

Function
REQ-018 The FSM states shall be IDLE, LAUNCH, WAIT and FINISH; GUs are served in ascending index order.
REQ-019 IDLE shall, on frame_tick: latch enable_mask into active_mask, set idx to the lowest set bit, and go to LAUNCH; if active_mask is 0, go to FINISH.
REQ-020 LAUNCH shall last exactly one cycle, assert gu_plot[idx] only, clear the watchdog, and go to WAIT.
REQ-021 gu_done is ignored while in LAUNCH.
REQ-022 In WAIT, vga_x/vga_y/vga_colour/vga_wren shall register the idx-selected GU signals, giving 1-cycle latency.
REQ-023 vga_wren shall be 0 in every state other than WAIT, and on the first cycle after leaving WAIT.
REQ-024 In WAIT, gu_done[idx]=1 shall advance to the next set bit above idx and go to LAUNCH; if no set bit remains, go to FINISH.
REQ-025 Done and write-enable from non-selected GUs shall be ignored.
REQ-026 The watchdog shall increment each WAIT cycle; on reaching WDOG_MAX it sets timeout and advances exactly as for done.
REQ-027 If done and watchdog expiry occur in the same cycle, done wins and timeout is not set.
REQ-028 FINISH shall pulse frame_done for one cycle and return to IDLE.
REQ-029 frame_tick while busy shall be dropped and shall set overrun; the sequence in progress is unaffected.
REQ-030 frame_tick in the same cycle as FINISH shall be treated as an overrun.
REQ-031 clr_status shall clear both sticky flags; a set event in the same cycle wins.
REQ-032 enable_mask changes after the frame_tick latch shall have no effect until the next frame.
REQ-033 gu_plot shall be mutually exclusive (one-hot or zero) in every cycle.

Reset
REQ-034 While resetn=0, the block shall asynchronously force: state IDLE, idx 0, active_mask 0, watchdog 0, and all outputs 0.
REQ-035 Reset mid-frame shall abandon the sequence with no further gu_plot; after release, the block waits in IDLE for frame_tick.

Verification
REQ-036 mask=3'b111, each GU done 10 cycles after its plot -> plots on GU0, GU1, GU2 in order; frame_done exactly once; busy high throughout.
REQ-037 GU1 drives wren=1, x=9'd319, y=8'd239, colour=3'b101 in WAIT -> vga outputs show the same values 1 cycle later; writes from GU0/GU2 during that time do not appear.
REQ-038 mask=3'b000 and frame_tick -> frame_done 2 cycles later; no gu_plot.
REQ-039 mask=3'b101, GU2 never asserts done, WDOG_MAX=16 -> GU1 skipped; timeout set after 16 WAIT cycles; frame_done follows.
REQ-040 Second frame_tick during GU0 WAIT -> overrun=1; the sequence completes normally; clr_status then clears overrun to 0.
REQ-041 resetn low during GU1 WAIT -> all outputs 0 immediately; no plot after release until the next frame_tick.
